// File: rtl/mux_pkg.sv
// Shared lane-index types for the 4-lane mux/demux pair.
package mux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

endpackage : mux_pkg

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter. The lane at ptr has top priority, then ptr+1,
// ptr+2 and ptr+3 (mod 4). After a grant, priority moves to the lane just past
// the winner, so a continuously requesting lane waits at most three grants.
module rr_arb4
  import mux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 adv,
  output lane_sel_t            gnt,
  output logic                 any_vld
);

  lane_sel_t ptr_reg;
  lane_sel_t ptr_next;
  lane_sel_t idx;

  // Scan from the lowest-priority offset up to the highest so the
  // highest-priority requester is the one left in gnt.
  always_comb begin
    gnt     = ptr_reg;
    idx     = ptr_reg;
    any_vld = |req;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr_reg + lane_sel_t'(k);
      if (req[idx]) begin
        gnt = idx;
      end
    end
  end

  // Priority moves past the winner only when a beat is actually taken.
  // The 2-bit add wraps from 3 to 0 on its own.
  always_comb begin
    ptr_next = ptr_reg;
    if (adv) begin
      ptr_next = gnt + 2'd1;
    end
  end

  // Pointer register. Lane 0 has top priority out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule : rr_arb4

// File: rtl/rr_mux4.sv
// Four-into-one round-robin collector. One beat is taken per cycle from the
// winning lane into a single output register, which carries the data together
// with the 2-bit index of the lane it came from. There is no combinational path
// from any din to dout.
module rr_mux4
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              vld0,
  input  logic              vld1,
  input  logic              vld2,
  input  logic              vld3,
  output logic              rdy0,
  output logic              rdy1,
  output logic              rdy2,
  output logic              rdy3,
  output logic [DATA_W-1:0] dout,
  output logic              s1,
  output logic              s0,
  output logic              dout_vld,
  input  logic              dout_rdy
);

  logic [DATA_W-1:0]    din_arr [NUM_LANES];
  logic [NUM_LANES-1:0] vld_vec;
  logic [NUM_LANES-1:0] rdy_vec;

  lane_sel_t         gnt;
  logic              any_vld;
  logic              load_en;
  logic              adv;
  logic              run_reg;

  logic [DATA_W-1:0] dout_reg;
  lane_sel_t         sel_reg;
  logic              dout_vld_reg;

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;
  assign vld_vec    = {vld3, vld2, vld1, vld0};

  // run_reg stays low from reset until the first clock edge after release, so
  // no lane is acked (and nothing is loaded) during or right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // The register can take a beat when it is empty or is being drained now.
  assign load_en = run_reg && (!dout_vld_reg || dout_rdy);
  assign adv     = load_en && any_vld;

  rr_arb4 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (vld_vec),
    .adv     (adv),
    .gnt     (gnt),
    .any_vld (any_vld)
  );

  // Only the winning lane sees rdy. It depends on the valids and the pointer,
  // never on the data of that lane.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_rdy
      assign rdy_vec[gi] = adv && (gnt == lane_sel_t'(gi));
    end
  endgenerate

  assign rdy0 = rdy_vec[0];
  assign rdy1 = rdy_vec[1];
  assign rdy2 = rdy_vec[2];
  assign rdy3 = rdy_vec[3];

  // Output register. If there is nothing to load, it empties but keeps the
  // last data and index. Under backpressure (load_en low) it holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg     <= '0;
      sel_reg      <= '0;
      dout_vld_reg <= 1'b0;
    end else if (load_en) begin
      if (any_vld) begin
        dout_reg     <= din_arr[gnt];
        sel_reg      <= gnt;
        dout_vld_reg <= 1'b1;
      end else begin
        dout_vld_reg <= 1'b0;
      end
    end
  end

  assign dout     = dout_reg;
  assign s1       = sel_reg[1];
  assign s0       = sel_reg[0];
  assign dout_vld = dout_vld_reg;

endmodule : rr_mux4

// File: tb/tb_rr_mux4.sv
// Directed bench for rr_mux4. A table of per-cycle vectors covers the
// single-lane, contention, backpressure, wrap and drain cases. Hand-written
// sequences cover reset at power-up and reset in the middle of operation.
module tb_rr_mux4;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [3:0] vld;
  logic       dout_rdy;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic [0:0] dout;
  logic       s1, s0;
  logic       dout_vld;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] din;
    logic       drdy;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic [1:0] exp_sel;
    logic       exp_dout;
  } vec_t;

  vec_t vecs [26];

  rr_mux4 #(.DATA_W(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .din0     (din[0:0]),
    .din1     (din[1:1]),
    .din2     (din[2:2]),
    .din3     (din[3:3]),
    .vld0     (vld[0]),
    .vld1     (vld[1]),
    .vld2     (vld[2]),
    .vld3     (vld[3]),
    .rdy0     (rdy0),
    .rdy1     (rdy1),
    .rdy2     (rdy2),
    .rdy3     (rdy3),
    .dout     (dout),
    .s1       (s1),
    .s0       (s0),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] d, logic r,
                              logic [3:0] er, logic ev, logic [1:0] es, logic ed);
    vec_t t;
    t.vld = v; t.din = d; t.drdy = r;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_sel = es; t.exp_dout = ed;
    return t;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_outs(string tag, logic ev, logic [1:0] es, logic ed);
    chk({tag, " dout_vld"}, {7'd0, dout_vld}, {7'd0, ev});
    chk({tag, " sel"}, {6'd0, s1, s0}, {6'd0, es});
    chk({tag, " dout"}, {7'd0, dout}, {7'd0, ed});
  endtask

  function automatic logic [3:0] rdy_now();
    return {rdy3, rdy2, rdy1, rdy0};
  endfunction

  initial begin
    // single lane 1
    vecs[0]  = mk(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1);
    vecs[1]  = mk(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1);
    vecs[2]  = mk(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1);
    // lane 3 alone brings ptr back to 0
    vecs[3]  = mk(4'b1000, 4'b1010, 1, 4'b1000, 1, 2'd3, 1);
    // full contention, din_i = i[0]
    vecs[4]  = mk(4'b1111, 4'b1010, 1, 4'b0001, 1, 2'd0, 0);
    vecs[5]  = mk(4'b1111, 4'b1010, 1, 4'b0010, 1, 2'd1, 1);
    vecs[6]  = mk(4'b1111, 4'b1010, 1, 4'b0100, 1, 2'd2, 0);
    vecs[7]  = mk(4'b1111, 4'b1010, 1, 4'b1000, 1, 2'd3, 1);
    vecs[8]  = mk(4'b1111, 4'b1010, 1, 4'b0001, 1, 2'd0, 0);
    vecs[9]  = mk(4'b1111, 4'b1010, 1, 4'b0010, 1, 2'd1, 1);
    // load lane 2, then backpressure for 5 cycles
    vecs[10] = mk(4'b1111, 4'b1010, 1, 4'b0100, 1, 2'd2, 0);
    vecs[11] = mk(4'b1111, 4'b1010, 0, 4'b0000, 1, 2'd2, 0);
    vecs[12] = mk(4'b1111, 4'b0101, 0, 4'b0000, 1, 2'd2, 0);
    vecs[13] = mk(4'b1111, 4'b1010, 0, 4'b0000, 1, 2'd2, 0);
    vecs[14] = mk(4'b1111, 4'b0101, 0, 4'b0000, 1, 2'd2, 0);
    vecs[15] = mk(4'b1111, 4'b1010, 0, 4'b0000, 1, 2'd2, 0);
    vecs[16] = mk(4'b1111, 4'b1010, 1, 4'b1000, 1, 2'd3, 1);
    // pointer wrap: last grant 3, lanes 0 and 3 request
    vecs[17] = mk(4'b1001, 4'b1010, 1, 4'b0001, 1, 2'd0, 0);
    vecs[18] = mk(4'b1001, 4'b1010, 1, 4'b1000, 1, 2'd3, 1);
    // idle drain after a single lane-2 beat
    vecs[19] = mk(4'b0100, 4'b1110, 1, 4'b0100, 1, 2'd2, 1);
    vecs[20] = mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd2, 1);
    vecs[21] = mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd2, 1);
    // dout_rdy low while empty still loads; then it holds
    vecs[22] = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 2'd0, 1);
    vecs[23] = mk(4'b0000, 4'b0000, 0, 4'b0000, 1, 2'd0, 1);
    vecs[24] = mk(4'b0010, 4'b0000, 0, 4'b0000, 1, 2'd0, 1);
    vecs[25] = mk(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1);

    // power-up reset, with every lane requesting
    rst = 1'b1; vld = 4'b1111; din = 4'b1111; dout_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por rdy", {4'd0, rdy_now()}, 8'h00);
    chk_outs("por", 1'b0, 2'd0, 1'b0);

    // release between edges: nothing acked before the next edge
    @(negedge clk);
    vld = 4'b0000; din = 4'b0000;
    rst = 1'b0;
    vld = 4'b0010;
    #1;
    chk("post-release rdy", {4'd0, rdy_now()}, 8'h00);
    vld = 4'b0000;
    @(posedge clk);
    #1;
    chk_outs("post-release", 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      vld = vecs[i].vld; din = vecs[i].din; dout_rdy = vecs[i].drdy;
      #1;
      chk($sformatf("v%0d rdy", i), {4'd0, rdy_now()}, {4'd0, vecs[i].exp_rdy});
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].exp_vld, vecs[i].exp_sel, vecs[i].exp_dout);
      $display("vec %0d: vld=%b din=%b drdy=%b rdy=%b -> dout_vld=%b sel=%0d dout=%b",
               i, vecs[i].vld, vecs[i].din, vecs[i].drdy, rdy_now(), dout_vld, {s1, s0}, dout);
    end

    // reset mid-cycle with a beat held (dout_vld=1, sel=1, dout=1)
    @(negedge clk);
    vld = 4'b1111; din = 4'b1111; dout_rdy = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst rdy", {4'd0, rdy_now()}, 8'h00);
    chk_outs("midrst", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0; vld = 4'b0100; din = 4'b0100; dout_rdy = 1'b1;
    #1;
    chk("midrst release rdy", {4'd0, rdy_now()}, 8'h00);
    @(posedge clk);
    #1;
    chk("midrst edge1 vld", {7'd0, dout_vld}, 8'h00);
    chk("midrst edge1 rdy", {4'd0, rdy_now()}, 8'h04);
    @(posedge clk);
    #1;
    chk_outs("midrst edge2", 1'b1, 2'd2, 1'b1);
    $display("midrst: dout_vld=%b sel=%0d dout=%b", dout_vld, {s1, s0}, dout);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_rr_mux4

// File: doc/rr_mux4.md
# rr_mux4

Four-into-one round-robin collector for single-bit (parameterisable) data lanes, the fan-in counterpart of the 1-to-4 demultiplexer. It arbitrates among four valid/ready input channels, registers the winning beat, and presents it on one output channel tagged with the 2-bit source index `{s1,s0}`. The block sits downstream of per-lane producers and feeds a single consumer, so the 2-bit index it emits can be fed straight back into a demultiplexer to reconstruct the lanes.

## Interface
Parameters:
- `DATA_W`, 1, width of each data lane.

Ports:
- `clk` in 1: single clock, all state rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `din0`..`din3` in `DATA_W`: lane data.
- `vld0`..`vld3` in 1: lane `i` offers a beat.
- `rdy0`..`rdy3` out 1: lane `i` beat accepted this cycle, when both `vld_i` and `rdy_i` are high.
- `dout` out `DATA_W`: registered output data.
- `s1`, `s0` out 1: registered source index of `dout`, MSB first.
- `dout_vld` out 1: output beat valid.
- `dout_rdy` in 1: consumer accepts the beat, when both `dout_vld` and `dout_rdy` are high.

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- One output register holds `dout`, `{s1,s0}` and `dout_vld`.
- `load_en = !dout_vld || dout_rdy`. The register can take a new beat when it is empty or is being drained this cycle.
- Arbiter:
  - 2-bit priority pointer `ptr`.
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The first lane with `vld_i` = 1 wins (`gnt`).
- `rdy_i = load_en && any_vld && (gnt == i)`:
  - Combinational.
  - At most one `rdy_i` is high per cycle.
  - `rdy_i` never depends on lane `i`'s own data.
- On a clock edge with `load_en`:
  - If any lane is valid: `dout <= din_gnt`, `{s1,s0} <= gnt`, `dout_vld <= 1`, `ptr <= gnt + 1`. The increment wraps from 3 to 0.
  - If no lane is valid: `dout_vld <= 0`. `dout`, `{s1,s0}` and `ptr` hold.
- Without `load_en` (`dout_vld` = 1 and `dout_rdy` = 0):
  - All registers hold.
  - All `rdy_i` = 0.
- Backpressure rules:
  - `dout` and `{s1,s0}` must stay stable while `dout_vld && !dout_rdy`.
  - Lanes may drop `vld_i` without a handshake. The arbiter re-evaluates every cycle.
- Fairness: every continuously valid lane is served within 4 output beats.

## Timing
- Reset values:
  - `dout` = 0, `s1` = 0, `s0` = 0, `dout_vld` = 0, `ptr` = 0 (lane 0 has top priority).
  - All `rdy_i` = 0 while `rst` is high.
- Latency: input handshake at edge N gives `dout_vld` = 1 with that data after edge N. One cycle, no combinational path from `din` to `dout`.
- Throughput: 1 beat/cycle with `dout_rdy` held high. Drain and load happen on the same edge.
- Simultaneous events:
  - When several lanes request, only the winner is acked.
  - Losers keep `vld` and are reconsidered next cycle under the updated pointer.
- Wrap-around: after a grant to lane 3, `ptr` = 0.
- Reset mid-operation:
  - A beat held in the output register is discarded.
  - `dout_vld` falls asynchronously with `rst`.
  - No `rdy_i` is asserted until the first clock edge after `rst` deasserts.
- `dout_rdy` while `dout_vld` = 0 is legal and has no effect beyond `load_en`.

## Structure
- Package `mux_pkg`:
  - `typedef logic [1:0] lane_sel_t`.
  - `localparam int NUM_LANES = 4`.
  - This package is shared with the demultiplexer-side index handling.
- Sub-module `rr_arb4`:
  - Inputs: `clk`, `rst`, `req[3:0]`, `adv`. The top level drives `adv` from `load_en && any_vld`.
  - Outputs: `gnt` (`lane_sel_t`), `any_vld`.
  - Holds `ptr`.
- The top level holds the output register and the `rdy`/`load_en` logic.

## Test plan
- Reset: assert `rst` mid-cycle with `dout_vld` = 1.
  - Immediately: `dout_vld` = 0, `dout` = 0, `{s1,s0}` = 0, all `rdy` = 0.
  - After release: a `vld2` beat with `din2` = 1 appears after one edge with `{s1,s0}` = 2, `dout` = 1.
- Single lane: `vld1` = 1, `din1` = 1, `dout_rdy` = 1.
  - `rdy1` = 1 each cycle.
  - Output stream `dout` = 1, `{s1,s0}` = 1, one beat per cycle.
- Full contention: all `vld` = 1 continuously, `dout_rdy` = 1, `din_i` = `i[0]`.
  - `{s1,s0}` sequence: 0, 1, 2, 3, 0, 1.
  - `dout` sequence: 0, 1, 0, 1, 0, 1.
- Backpressure: `dout_vld` = 1 with `{s1,s0}` = 2; hold `dout_rdy` = 0 for 5 cycles with all `vld` high.
  - `dout` and `{s1,s0}` are stable for those cycles.
  - All `rdy` = 0.
  - On releasing `dout_rdy`, the next beat is `{s1,s0}` = 3.
- Pointer wrap: last grant was lane 3; then `vld0` = `vld3` = 1.
  - Lane 0 is granted first (`rdy0` = 1).
  - Lane 3 is granted next.
- Idle drain: single beat accepted, then no `vld`, `dout_rdy` = 1.
  - `dout_vld` = 1 for exactly one cycle, then 0.
  - `{s1,s0}` and `dout` hold their last values.
